bch_stream_encoder: RTL and testbench

Parametrised systematic binary BCH encoder with streaming valid/ready handshakes on both sides, the next generation of the serial `bch_encoder`. It sits in the transmit chain between the bit source and the modulator. It consumes K message bits per codeword and emits N code bits: K message bits passed through, then N−K parity bits. The remainder is computed in an LFSR defined by a generator-polynomial parameter, so one RTL serves any (N,K) binary cyclic code. Backpressure is supported on both sides, and a block-level parity word is also exported.

---
 rtl/bch_pkg.sv | 15 +
 rtl/bch_lfsr_step.sv | 19 +
 rtl/bch_stream_encoder.sv | 129 ++++++++++++
 tb/tb_bch_stream_encoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH streaming encoder family.
package bch_pkg;

  localparam int          BCH63_51_N = 63;
  localparam int          BCH63_51_K = 51;
  localparam logic [12:0] BCH63_51_G = 13'h1539;

  // MSG: message bits pass through while the remainder is accumulated.
  // PAR: the remainder is shifted out as parity.
  typedef enum logic {
    MSG = 1'b0,
    PAR = 1'b1
  } bch_enc_state_t;

endpackage

// File: rtl/bch_lfsr_step.sv
// One combinational step of an R-bit polynomial division register.
// shift_only_i=0: divide step with incoming bit_i. shift_only_i=1: plain shift.
module bch_lfsr_step #(
  parameter int         R        = 12,
  parameter logic [R:0] GEN_POLY = 13'h1539
) (
  input  logic [R-1:0] lfsr_i,
  input  logic         bit_i,
  input  logic         shift_only_i,
  output logic [R-1:0] lfsr_o
);

  logic fb;

  // Feedback taps are only applied in divide mode.
  assign fb     = !shift_only_i && (bit_i ^ lfsr_i[R-1]);
  assign lfsr_o = (lfsr_i << 1) ^ (fb ? GEN_POLY[R-1:0] : '0);

endmodule

// File: rtl/bch_stream_encoder.sv
// Systematic binary cyclic/BCH encoder, one bit per cycle, valid/ready on
// both sides. Emits K message bits then R=N-K parity bits MSB first.
module bch_stream_encoder
  import bch_pkg::*;
#(
  parameter int           N        = BCH63_51_N,
  parameter int           K        = BCH63_51_K,
  parameter logic [N-K:0] GEN_POLY = BCH63_51_G
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic           s_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           m_data,
  output logic           m_last,
  output logic [N-K-1:0] parity_out,
  output logic           parity_valid
);

  localparam int R    = N - K;
  localparam int CMAX = (K > R) ? K : R;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] R_LAST = CW'(R - 1);

  bch_enc_state_t state_q, state_d;
  logic [R-1:0]   lfsr_q, lfsr_d, lfsr_step;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           m_data_q, m_data_d;
  logic           m_valid_q, m_valid_d;
  logic           m_last_q, m_last_d;
  logic [R-1:0]   parity_q, parity_d;
  logic           pvld_q, pvld_d;
  logic           slot_free;

  // Divide in MSG, plain shift-out in PAR.
  bch_lfsr_step #(.R(R), .GEN_POLY(GEN_POLY)) u_step (
    .lfsr_i      (lfsr_q),
    .bit_i       (s_data),
    .shift_only_i(state_q == PAR),
    .lfsr_o      (lfsr_step)
  );

  assign slot_free = !m_valid_q || m_ready;

  // Next-state: load the output register whenever it is free and a bit is available.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    m_data_d = m_data_q;
    // Consumed with nothing new loaded: drop valid; held: keep everything.
    m_valid_d = m_valid_q && !m_ready;
    m_last_d  = (m_valid_q && !m_ready) ? m_last_q : 1'b0;
    parity_d  = parity_q;
    pvld_d    = 1'b0;
    s_ready   = 1'b0;
    unique case (state_q)
      MSG: begin
        s_ready = slot_free;
        if (s_valid && slot_free) begin
          lfsr_d    = lfsr_step;
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          if (cnt_q == K_LAST) begin
            cnt_d   = '0;
            state_d = PAR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (slot_free) begin
          lfsr_d    = lfsr_step;
          m_data_d  = lfsr_q[R-1];
          m_valid_d = 1'b1;
          m_last_d  = (cnt_q == R_LAST);
          // The register still holds the complete remainder on the first shift.
          if (cnt_q == '0) begin
            parity_d = lfsr_q;
            pvld_d   = 1'b1;
          end
          if (cnt_q == R_LAST) begin
            cnt_d   = '0;
            state_d = MSG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = MSG;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MSG;
      lfsr_q    <= '0;
      cnt_q     <= '0;
      m_data_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      parity_q  <= '0;
      pvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      parity_q  <= parity_d;
      pvld_q    <= pvld_d;
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign parity_out   = parity_q;
  assign parity_valid = pvld_q;

endmodule

// File: tb/tb_bch_stream_encoder.sv
// Self-checking bench: polynomial long-division model plus scoreboard.
module tb_bch_stream_encoder;

  localparam int N = 63;
  localparam int K = 51;
  localparam int R = N - K;

  typedef struct { bit d; bit l; } ob_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         s_valid = 1'b0, s_data = 1'b0, m_ready = 1'b1;
  logic         s_ready, m_valid, m_data, m_last, parity_valid;
  logic [R-1:0] parity_out;

  logic         s_valid_b = 1'b0, s_data_b = 1'b0, m_ready_b = 1'b1;
  logic         s_ready_b, m_valid_b, m_data_b, m_last_b, parity_valid_b;
  logic [7:0]   parity_out_b;

  bch_stream_encoder dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .parity_out(parity_out), .parity_valid(parity_valid)
  );

  bch_stream_encoder #(.N(15), .K(7), .GEN_POLY(9'h1D1)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b),
    .parity_out(parity_out_b), .parity_valid(parity_valid_b)
  );

  int errors = 0, checks = 0, cyc = 0, pv_count = 0;
  bit thr = 1'b0;
  ob_t exp_q[$];
  logic [R-1:0] par_q[$];
  int last_cyc[$];
  bit ob_b[$], lb_b[$];
  bit held = 1'b0, hd = 1'b0, hl = 1'b0;
  ob_t e;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Remainder of m(x)*x^(n-k) divided by g(x); msg[i] is the coefficient of x^i.
  function automatic bit [62:0] enc_parity(bit [62:0] msg, int n, int k, bit [12:0] g);
    bit [63:0] c;
    bit [62:0] rem;
    int r;
    r = n - k;
    c = '0;
    rem = '0;
    for (int i = 0; i < k; i++) c[i+r] = msg[i];
    for (int d = n - 1; d >= r; d--)
      if (c[d]) for (int j = 0; j <= r; j++) c[d-r+j] ^= g[j];
    for (int i = 0; i < r; i++) rem[i] = c[i];
    return rem;
  endfunction

  // Queue the expected codeword, then offer the first nbits message bits.
  task automatic send_cw(input bit [62:0] msg, input int nbits);
    bit [62:0] par;
    int guard;
    par = enc_parity(msg, N, K, 13'h1539);
    for (int i = K - 1; i >= 0; i--) exp_q.push_back('{d: msg[i], l: 1'b0});
    for (int i = R - 1; i >= 0; i--) exp_q.push_back('{d: par[i], l: (i == 0)});
    par_q.push_back(par[R-1:0]);
    for (int idx = 0; idx < nbits; idx++) begin
      guard = 0;
      forever begin
        @(posedge clk); #1;
        s_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data  = msg[K-1-idx];
        @(negedge clk);
        if (s_valid && s_ready) break;
        guard++;
        if (guard > 2000) begin
          fail("send_timeout");
          s_valid = 1'b0;
          return;
        end
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || par_q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  // Downstream backpressure source.
  initial forever begin
    @(posedge clk); #1;
    m_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every transfer, every held cycle, every parity pulse.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(m_valid), 64'(1));
        chk("hold_data", 64'(m_data), 64'(hd));
        chk("hold_last", 64'(m_last), 64'(hl));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) fail("unexpected_output");
        else begin
          e = exp_q.pop_front();
          chk("m_data", 64'(m_data), 64'(e.d));
          chk("m_last", 64'(m_last), 64'(e.l));
        end
        if (m_last) last_cyc.push_back(cyc);
      end
      held = m_valid && !m_ready;
      hd = m_data;
      hl = m_last;
      if (parity_valid) begin
        pv_count++;
        if (par_q.size() == 0) fail("unexpected_parity_valid");
        else chk("parity_out", 64'(parity_out), 64'(par_q.pop_front()));
      end
    end
  end

  // Collector for the small-code instance (m_ready_b is tied high).
  always @(negedge clk) begin
    if (!rst && m_valid_b) begin
      ob_b.push_back(m_data_b);
      lb_b.push_back(m_last_b);
    end
  end

  initial begin
    bit [62:0] msg;
    bit [50:0] gm;
    bit [7:0]  pb;
    bit [6:0]  mb;
    int pv0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_parity_valid", 64'(parity_valid), 64'(0));
    chk("rst_parity_out", 64'(parity_out), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_rst", 64'(s_ready), 64'(1));

    // Hand-computed anchors for the model
    chk("model_x0", 64'(enc_parity(63'd1, 63, 51, 13'h1539)), 64'h539);
    chk("model_15_7", 64'(enc_parity(63'd1, 15, 7, 13'h1D1)), 64'hD1);

    // All-zero message
    send_cw(63'd0, K);
    wait_drain();
    chk("parity_zero", 64'(parity_out), 64'h000);

    // Only x^0 set
    pv0 = pv_count;
    send_cw(63'd1, K);
    wait_drain();
    chk("pv_once", 64'(pv_count - pv0), 64'(1));
    chk("parity_x0", 64'(parity_out), 64'h539);

    // Fixed message, three codewords back-to-back, no idle cycles
    gm = 51'b011111100000110011101001010100011001001011110100100;
    msg = 63'(gm);
    last_cyc.delete();
    repeat (3) send_cw(msg, K);
    wait_drain();
    chk("b2b_count", 64'(last_cyc.size()), 64'(3));
    if (last_cyc.size() == 3) begin
      chk("b2b_gap1", 64'(last_cyc[1] - last_cyc[0]), 64'(N));
      chk("b2b_gap2", 64'(last_cyc[2] - last_cyc[1]), 64'(N));
    end

    // Random throttling on both sides
    thr = 1'b1;
    for (int n = 0; n < 100; n++) begin
      msg = 63'({$urandom(), $urandom()}) & ((63'd1 << K) - 63'd1);
      send_cw(msg, K);
    end
    wait_drain();
    thr = 1'b0;

    // Reset after 20 message bits, then a clean codeword
    msg = 63'({$urandom(), $urandom()}) & ((63'd1 << K) - 63'd1);
    send_cw(msg, 20);
    rst = 1'b1;
    exp_q.delete();
    par_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_valid", 64'(m_valid), 64'(0));
    chk("midrst_m_data", 64'(m_data), 64'(0));
    chk("midrst_m_last", 64'(m_last), 64'(0));
    chk("midrst_parity_valid", 64'(parity_valid), 64'(0));
    chk("midrst_parity_out", 64'(parity_out), 64'(0));
    chk("midrst_s_ready", 64'(s_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    msg = 63'({$urandom(), $urandom()}) & ((63'd1 << K) - 63'd1);
    send_cw(msg, K);
    wait_drain();

    // BCH(15,7) instance: message with only x^0 set
    ob_b.delete();
    lb_b.delete();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      s_valid_b = 1'b1;
      s_data_b  = (i == 6);
    end
    @(posedge clk); #1;
    s_valid_b = 1'b0;
    repeat (25) @(negedge clk);
    chk("b_len", 64'(ob_b.size()), 64'(15));
    if (ob_b.size() == 15) begin
      mb = '0;
      pb = '0;
      for (int i = 0; i < 7; i++) mb = {mb[5:0], ob_b[i]};
      for (int i = 7; i < 15; i++) pb = {pb[6:0], ob_b[i]};
      chk("b_msg_bits", 64'(mb), 64'h01);
      chk("b_parity_bits", 64'(pb), 64'hD1);
      chk("b_last", 64'(lb_b[14]), 64'(1));
      chk("b_last_early", 64'(lb_b[13]), 64'(0));
    end
    chk("b_parity_out", 64'(parity_out_b), 64'hD1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #900000;
    fail("global_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
